// File: rtl/ttt_processor_array.sv
// Time-multiplexed token-threshold neuron array: one shared datapath visits each neuron slot per clock.
// Optional macro TTT_DECAY_EN: inactive accumulators leak by one token per visit.
module ttt_processor_array #(
    parameter int NEW_TOKENS_BITS = 8,
    parameter int TOKENS_BITS     = 8,
    parameter int DURATION_BITS   = 8,
    parameter int NUM_PROCESSORS  = 10,
    parameter int PROG_WIDTH      = 8,
    localparam int ID_W           = $clog2(NUM_PROCESSORS)
) (
    input  logic                       clock_fast,
    input  logic                       reset,
    input  logic                       hold,
    output logic [ID_W-1:0]            scan_id,
    input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    output logic                       out_valid,
    output logic [ID_W-1:0]            out_id,
    output logic                       token_start,
    output logic                       token_stop,
    output logic                       sweep_done,
    input  logic                       prog_valid,
    input  logic [2:0]                 prog_header,
    input  logic [ID_W-1:0]            prog_addr,
    input  logic [PROG_WIDTH-1:0]      prog_data
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCESSORS - 1);
    localparam int SW = TOKENS_BITS + NEW_TOKENS_BITS + 1;

    logic [TOKENS_BITS-1:0]   tokens_q    [NUM_PROCESSORS];
    logic [TOKENS_BITS-1:0]   tokens_d    [NUM_PROCESSORS];
    logic [TOKENS_BITS-1:0]   threshold_q [NUM_PROCESSORS];
    logic [TOKENS_BITS-1:0]   threshold_d [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] duration_q  [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] duration_d  [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] remaining_q [NUM_PROCESSORS];
    logic [DURATION_BITS-1:0] remaining_d [NUM_PROCESSORS];
    logic                     active_q    [NUM_PROCESSORS];
    logic                     active_d    [NUM_PROCESSORS];

    logic [ID_W-1:0] scan_q, scan_d, out_id_q, out_id_d;
    logic            valid_q, valid_d, start_q, start_d, stop_q, stop_d, done_q, done_d;

    logic [TOKENS_BITS-1:0] tok_cur, base, sum_c;
    logic signed [SW-1:0]   sum_s;
    logic                   upd, prog_ok, clr_hit;

    // Saturating sum for the neuron currently under the scan pointer
    always_comb begin
        tok_cur = tokens_q[scan_q];
        base    = tok_cur;
`ifdef TTT_DECAY_EN
        if (!active_q[scan_q] && tok_cur != '0) base = tok_cur - 1'b1;
`endif
        sum_s = $signed({{(SW-TOKENS_BITS){1'b0}}, base})
              + $signed({{(SW-NEW_TOKENS_BITS){1'b0}}, new_good_tokens})
              - $signed({{(SW-NEW_TOKENS_BITS){1'b0}}, new_bad_tokens});
        if (sum_s[SW-1])                    sum_c = '0;
        else if (|sum_s[SW-2:TOKENS_BITS])  sum_c = '1;
        else                                sum_c = sum_s[TOKENS_BITS-1:0];
    end

    always_comb begin
        tokens_d    = tokens_q;
        threshold_d = threshold_q;
        duration_d  = duration_q;
        remaining_d = remaining_q;
        active_d    = active_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        upd         = !hold;
        prog_ok     = prog_valid && (prog_addr <= LAST_ID);
        clr_hit     = prog_ok && (prog_header == 3'd2) && (prog_addr == scan_q);

        if (upd && !clr_hit) begin
            if (!active_q[scan_q]) begin
                tokens_d[scan_q] = sum_c;
                if (sum_c >= threshold_q[scan_q]) begin
                    start_d = 1'b1;
                    if (duration_q[scan_q] == '0) begin
                        stop_d           = 1'b1;
                        tokens_d[scan_q] = '0;
                    end else begin
                        active_d[scan_q]    = 1'b1;
                        remaining_d[scan_q] = duration_q[scan_q];
                    end
                end
            end else if (remaining_q[scan_q] > DURATION_BITS'(1)) begin
                remaining_d[scan_q] = remaining_q[scan_q] - 1'b1;
                tokens_d[scan_q]    = sum_c;
            end else begin
                stop_d              = 1'b1;
                active_d[scan_q]    = 1'b0;
                tokens_d[scan_q]    = '0;
                remaining_d[scan_q] = '0;
            end
        end

        // Programming lands after the slot update so it wins on a collision
        if (prog_ok) begin
            case (prog_header)
                3'd0: threshold_d[prog_addr] = prog_data[TOKENS_BITS-1:0];
                3'd1: duration_d[prog_addr]  = prog_data[DURATION_BITS-1:0];
                3'd2: begin
                    tokens_d[prog_addr]    = '0;
                    active_d[prog_addr]    = 1'b0;
                    remaining_d[prog_addr] = '0;
                end
                default: ;
            endcase
        end

        valid_d  = upd;
        out_id_d = upd ? scan_q : out_id_q;
        done_d   = upd && (scan_q == LAST_ID);
        scan_d   = !upd ? scan_q : (scan_q == LAST_ID) ? '0 : scan_q + 1'b1;
    end

    always_ff @(posedge clock_fast) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                tokens_q[i]    <= '0;
                threshold_q[i] <= '1;
                duration_q[i]  <= '0;
                remaining_q[i] <= '0;
                active_q[i]    <= 1'b0;
            end
            scan_q   <= '0;
            out_id_q <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tokens_q    <= tokens_d;
            threshold_q <= threshold_d;
            duration_q  <= duration_d;
            remaining_q <= remaining_d;
            active_q    <= active_d;
            scan_q      <= scan_d;
            out_id_q    <= out_id_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
        end
    end

    assign scan_id     = scan_q;
    assign out_valid   = valid_q;
    assign out_id      = out_id_q;
    assign token_start = start_q;
    assign token_stop  = stop_q;
    assign sweep_done  = done_q;

endmodule

// File: doc/ttt_processor_array.md
Name: ttt_processor_array

Overview:
- Time-multiplexed token-threshold neuron processor: one shared datapath sweeps NUM_PROCESSORS neuron state slots round-robin, one neuron per clock.
- Successor to the single processor core. Adds a single clock domain, an internal scan sequencer, addressed programming of per-neuron threshold and duration, a saturating token accumulator, and output tagging with neuron id.
- Sits between the token-input router, which drives tokens for the neuron named on scan_id, and the spike output encoder.

Parameters:
- NEW_TOKENS_BITS, 8, width of per-cycle good/bad token increments
- TOKENS_BITS, 8, width of per-neuron token accumulator
- DURATION_BITS, 8, width of per-neuron duration counter
- NUM_PROCESSORS, 10, number of neuron state slots (>=2)
- PROG_WIDTH, 8, programming data width; must be >= max(TOKENS_BITS, DURATION_BITS)

Ports:
- clock_fast  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- hold  in  1  freeze sweep; inputs ignored while high
- scan_id  out  $clog2(NUM_PROCESSORS)  neuron whose tokens are sampled this cycle
- new_good_tokens  in  NEW_TOKENS_BITS  tokens added to neuron scan_id
- new_bad_tokens  in  NEW_TOKENS_BITS  tokens removed from neuron scan_id
- out_valid  out  1  out_id/token_start/token_stop valid this cycle
- out_id  out  $clog2(NUM_PROCESSORS)  neuron the outputs refer to
- token_start  out  1  neuron out_id began firing
- token_stop  out  1  neuron out_id finished firing
- sweep_done  out  1  pulse: last neuron of a sweep processed
- prog_valid  in  1  programming write strobe
- prog_header  in  3  field select
- prog_addr  in  $clog2(NUM_PROCESSORS)  target neuron
- prog_data  in  PROG_WIDTH  write value, LSB-aligned

Behaviour:
- Reset (reset==0 at clock edge):
  - scan_id=0; out_valid, out_id, token_start, token_stop, sweep_done all 0.
  - Every slot: tokens=0, active=0, remaining=0, threshold=all-ones, duration=0.
  - Reset mid-sweep discards all state; the sweep restarts at 0.
- Sweep:
  - When hold==0, scan_id increments each cycle and wraps from NUM_PROCESSORS-1 to 0.
  - When hold==1, scan_id holds, no slot updates, and out_valid, token_start, token_stop, sweep_done are all 0.
- Update for n=scan_id in cycle t, with results registered at t+1 (latency 1):
  - sum = tokens + good - bad, computed at TOKENS_BITS+NEW_TOKENS_BITS+1 bits signed, then clamped to [0, 2^TOKENS_BITS-1].
  - If !active and sum>=threshold: token_start=1, active=1, remaining=duration, tokens=sum.
    - If duration==0, token_stop=1 in the same cycle and the neuron goes inactive with tokens=0.
  - If active and remaining>1: remaining-=1, tokens=sum.
  - If active and remaining<=1: token_stop=1, active=0, tokens=0, remaining=0.
  - If active, no new start occurs until after the stop.
- Outputs at t+1: out_valid=1, out_id=n, sweep_done=(n==NUM_PROCESSORS-1).
- Programming (any time, 1-cycle write):
  - header 0: threshold[addr] = prog_data[TOKENS_BITS-1:0].
  - header 1: duration[addr] = prog_data[DURATION_BITS-1:0]. Takes effect at the next start; an in-flight remaining count is unaffected.
  - header 2: clear slot addr (tokens, active, remaining = 0) with no output pulses.
  - headers 3-7: no-op.
  - prog_addr >= NUM_PROCESSORS: ignored.
  - Collision (prog_addr==scan_id in the same cycle): the programming write takes priority for the written field. For header 2 the slot update is suppressed and outputs for that neuron are 0 (out_valid still 1).

Optional Feature:
- Macro TTT_DECAY_EN.
- Defined: each inactive neuron's accumulator leaks by 1 before the sum, i.e. sum = max(tokens-1,0) + good - bad (then clamped), so idle neurons drain to 0.
- Undefined: no leak; tokens persist indefinitely between inputs.

Test Plan:
- Reset then idle 10 cycles with zero tokens -> scan_id 0..9 then wraps to 0; token_start never asserts; sweep_done pulses once, on out_id==9.
- Program threshold[3]=5, duration[3]=2; drive good=5 when scan_id==3 -> next cycle out_id=3, token_start=1. Two sweeps later, on out_id=3, token_stop=1.
- Saturation: good=255, bad=0 three visits to neuron 0 (threshold 255, duration 3) -> fires on the first visit; tokens clamp at 255. Then bad=255 with good=0 -> tokens clamp at 0 and never wrap.
- duration[5]=0, threshold[5]=1, good=1 -> token_start and token_stop both 1 on out_id=5 in the same cycle.
- Assert hold for 4 cycles mid-sweep at scan_id=6 -> scan_id stays 6; out_valid=0; the neuron 6 input is ignored. Release -> processing resumes at 6.
- Header-2 clear of an active neuron 2 coinciding with scan_id==2 -> no token_stop is emitted; the next visit shows active=0 behaviour (can restart). Then reset mid-fire -> all outputs 0 and scan_id=0 the following cycle.
